apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one APB bus between NUM_REQ local requesters.
- Each requester presents rw/addr/wdata with a valid.
- Block grants one requester, drives the APB SETUP/ACCESS sequence, waits on P_ready, and returns rdata/error with a one-cycle done pulse.
- Sits between internal initiators (DMA, CPU shim, debug port) and APB slaves.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 8, APB address width
- DATA_W, 8, APB data width
- TIMEOUT_CYCLES, 16, max ACCESS wait cycles; used only with APB_TIMEOUT_EN

Ports:
- P_clk  in  1  bus clock, all logic on rising edge
- P_reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request, held until its done
- req_rw  in  NUM_REQ  per-requester direction, 1=write
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened write data, same packing
- req_grant  out  NUM_REQ  one-hot current owner, 0 when idle
- req_done  out  NUM_REQ  one-hot, one-cycle completion pulse
- req_err  out  1  error status, valid with req_done
- req_rdata  out  DATA_W  read data, valid with req_done on reads
- P_sel  out  1  APB select
- P_enable  out  1  APB enable
- P_write  out  1  APB direction
- P_addr  out  ADDR_W  APB address
- P_wdata  out  DATA_W  APB write data
- P_rdata  in  DATA_W  APB read data
- P_ready  in  1  APB ready
- P_slverr  in  1  APB slave error

Behaviour:
- Clock and reset: one clock, P_clk. P_reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; round-robin pointer ptr=0; timeout counter 0.
- Reset mid-transfer: at the next edge, P_sel=P_enable=0 and state=IDLE. No done pulse. The aborted transfer is lost.
- States: IDLE, SETUP, ACCESS (2-bit encoding).
- IDLE:
  - Arbitrate req_valid. Search starts at index ptr and wraps modulo NUM_REQ; the first asserted requester wins.
  - On a win: P_sel<=1, P_enable<=0, P_addr<=winner addr, P_write<=winner rw, grant<=one-hot winner, go SETUP.
  - P_wdata is loaded only when rw=1; otherwise it holds its previous value.
  - Request fields are captured once. Later changes on the requester inputs are ignored until done.
- SETUP: exactly one cycle; P_enable<=1, go ACCESS.
- ACCESS:
  - P_ready=0: hold all APB outputs.
  - P_ready=1: P_sel<=0, P_enable<=0, grant<=0.
  - Same edge: req_done[winner]<=1, req_err<=P_slverr, req_rdata<=P_rdata if read (else unchanged), ptr<=(winner+1) mod NUM_REQ, go IDLE.
- req_done and req_err clear automatically after one cycle.
- Latency: request seen in IDLE at cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> done cycle 3 (zero wait states). Each P_ready-low cycle adds one cycle.
- Back-to-back: the IDLE cycle that carries a done may start the next grant, so P_sel toggles low for exactly one cycle between transfers.
- Masking: a requester whose req_done is high in the current cycle is excluded from arbitration in that cycle. This prevents a re-grant on a stale valid.
- req_valid dropped mid-transfer: the transfer completes normally and done still pulses.
- P_slverr is sampled only in ACCESS with P_ready=1; it is ignored elsewhere.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- When defined:
  - A counter increments on every ACCESS cycle with P_ready=0 and clears on leaving ACCESS.
  - When the counter reaches TIMEOUT_CYCLES: terminate as a completion with req_err=1 and req_rdata=0, P_sel/P_enable<=0, go IDLE, ptr advances as normal.
  - P_ready arriving on that same cycle takes priority: the transfer completes normally.
- When undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES unused.

Test Plan:
- Single write: req0 rw=1 addr=0x12 wdata=0xA5, P_ready tied 1 -> P_sel cycle1, P_enable cycle2, P_addr=0x12, P_wdata=0xA5, P_write=1; req_done=0001 cycle3, req_err=0.
- Read with 2 wait states: req2 rw=0 addr=0x40, P_ready low 2 cycles then high with P_rdata=0x3C -> ACCESS held 3 cycles, req_done=0100, req_rdata=0x3C at cycle 5.
- Fairness: req0..req3 all held valid, ptr=0 -> grant order 0,1,2,3,0; req1 done masks it in its done cycle; P_sel low exactly one cycle between transfers.
- Slave error: req3 write, P_slverr=1 with P_ready -> req_done=1000, req_err=1 for one cycle, next transfer err=0.
- Reset mid-ACCESS: P_reset high while P_ready=0 -> next edge all outputs 0, no req_done; after release, req0 re-granted first.
- APB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, P_ready stuck 0 -> done with err=1, rdata=0 after 16 ACCESS cycles; undefined -> P_sel stays high 100+ cycles.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter sharing one APB bus between NUM_REQ requesters.
// Ports: P_clk/P_reset (sync, active-high); req_valid/req_rw/req_addr/req_wdata per-requester
// requests (flattened, requester i at [i*W +: W]); req_grant/req_done one-hot owner and
// completion pulse; req_err/req_rdata completion status; P_* APB master signals.
// Optional macro APB_TIMEOUT_EN terminates an ACCESS phase after TIMEOUT_CYCLES wait cycles.
module apb_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      P_clk,
    input  logic                      P_reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        req_done,
    output logic                      req_err,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      P_sel,
    output logic                      P_enable,
    output logic                      P_write,
    output logic [ADDR_W-1:0]         P_addr,
    output logic [DATA_W-1:0]         P_wdata,
    input  logic [DATA_W-1:0]         P_rdata,
    input  logic                      P_ready,
    input  logic                      P_slverr
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state, state_d;
    logic [IW-1:0] ptr, own, win, idx;
    logic [NUM_REQ-1:0] avail;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic found, tmo, fin;
`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign tmo = state == ACCESS && !P_ready && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge P_clk)
        cnt <= (P_reset || state != ACCESS || P_ready || tmo) ? '0 : cnt + 1'b1;
`else
    // Constant false; TIMEOUT_CYCLES only matters when the timeout is built in.
    assign tmo = TIMEOUT_CYCLES < 0;
`endif
    assign fin = state == ACCESS && (P_ready || tmo);
    always_comb begin
        // A requester whose done is pulsing still shows its stale valid; keep it out.
        avail = req_valid & ~req_done;
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(ptr) + k) % NUM_REQ);
            if (!found && avail[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        win_addr  = ADDR_W'(req_addr >> (int'(win) * ADDR_W));
        win_wdata = DATA_W'(req_wdata >> (int'(win) * DATA_W));
        state_d   = state == IDLE  ? (found ? SETUP : IDLE) :
                    state == SETUP ? ACCESS : (fin ? IDLE : ACCESS);
    end
    always_ff @(posedge P_clk)
        state <= P_reset ? IDLE : state_d;
    always_ff @(posedge P_clk) begin
        if (P_reset) begin
            ptr       <= '0;
            own       <= '0;
            req_grant <= '0;
            req_done  <= '0;
            req_err   <= 1'b0;
            req_rdata <= '0;
            P_sel     <= 1'b0;
            P_enable  <= 1'b0;
            P_write   <= 1'b0;
            P_addr    <= '0;
            P_wdata   <= '0;
        end else begin
            req_done <= fin ? NUM_REQ'(1) << own : '0;
            req_err  <= fin && (P_ready ? P_slverr : 1'b1);
            if (state == IDLE && found) begin
                P_sel     <= 1'b1;
                P_enable  <= 1'b0;
                P_addr    <= win_addr;
                P_write   <= req_rw[win];
                own       <= win;
                req_grant <= NUM_REQ'(1) << win;
                if (req_rw[win]) P_wdata <= win_wdata;
            end
            if (state == SETUP) P_enable <= 1'b1;
            if (fin) begin
                P_sel     <= 1'b0;
                P_enable  <= 1'b0;
                req_grant <= '0;
                ptr       <= own == IW'(NUM_REQ - 1) ? '0 : own + 1'b1;
                if (!P_ready) req_rdata <= '0;
                else if (!P_write) req_rdata <= P_rdata;
            end
        end
    end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: table-driven directed bench for apb_req_arbiter (NUM_REQ=4, 8-bit bus).
module tb_apb_req_arbiter;
    logic       P_clk = 1'b0, P_reset = 1'b1;
    logic [3:0] req_valid = '0, req_rw = '0, req_grant, req_done;
    logic [31:0] req_addr, req_wdata;
    logic       req_err, P_sel, P_enable, P_write, P_ready = 1'b0, P_slverr = 1'b0;
    logic [7:0] req_rdata, P_addr, P_wdata, P_rdata = '0;
    assign req_addr  = {8'h33, 8'h40, 8'h21, 8'h12};
    assign req_wdata = {8'hD8, 8'hC7, 8'hB6, 8'hA5};
    always #5 P_clk = ~P_clk;
    apb_req_arbiter dut (
        .P_clk(P_clk), .P_reset(P_reset), .req_valid(req_valid), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_grant(req_grant), .req_done(req_done),
        .req_err(req_err), .req_rdata(req_rdata), .P_sel(P_sel), .P_enable(P_enable),
        .P_write(P_write), .P_addr(P_addr), .P_wdata(P_wdata), .P_rdata(P_rdata),
        .P_ready(P_ready), .P_slverr(P_slverr)
    );
    typedef struct {
        logic rst; logic [3:0] v, rw; logic rdy, se; logic [7:0] prd;
        logic [3:0] g, d; logic e; logic [7:0] rd; logic s, en, wr; logic [7:0] a, wd;
    } vec_t;
    vec_t tv[$];
    int errs = 0, checks = 0;
    function automatic void add(logic rst, logic [3:0] v, rw, logic rdy, se, logic [7:0] prd,
                                logic [3:0] g, d, logic e, logic [7:0] rd, logic s, en, wr,
                                logic [7:0] a, wd);
        tv.push_back('{rst, v, rw, rdy, se, prd, g, d, e, rd, s, en, wr, a, wd});
    endfunction
    task automatic chk(input string n, input int row, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s row %0d: got %0h expected %0h", n, row, act, exp);
        end
    endtask
    task automatic step;
        @(posedge P_clk);
        #1;
    endtask
    task automatic do_reset;
        P_reset = 1'b1; req_valid = '0; req_rw = '0; P_ready = 1'b0; P_slverr = 1'b0;
        step();
        P_reset = 1'b0;
    endtask
    initial begin
        int n, bad;
        //  rst v    rw   rdy se prd     | g    d    e rd     s  en wr a      wd
        add(1, 4'h0, 4'h0, 0, 0, 8'h00,  4'h0, 4'h0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        add(0, 4'h1, 4'h1, 1, 0, 8'h00,  4'h1, 4'h0, 0, 8'h00, 1, 0, 1, 8'h12, 8'hA5);
        add(0, 4'h1, 4'h1, 1, 0, 8'h00,  4'h1, 4'h0, 0, 8'h00, 1, 1, 1, 8'h12, 8'hA5);
        add(0, 4'h1, 4'h1, 1, 0, 8'h00,  4'h0, 4'h1, 0, 8'h00, 0, 0, 1, 8'h12, 8'hA5);
        add(0, 4'h1, 4'h1, 1, 0, 8'h00,  4'h0, 4'h0, 0, 8'h00, 0, 0, 1, 8'h12, 8'hA5);
        add(0, 4'h0, 4'h0, 1, 0, 8'h00,  4'h0, 4'h0, 0, 8'h00, 0, 0, 1, 8'h12, 8'hA5);
        add(0, 4'h4, 4'h0, 0, 0, 8'h00,  4'h4, 4'h0, 0, 8'h00, 1, 0, 0, 8'h40, 8'hA5);
        add(0, 4'h4, 4'h0, 0, 0, 8'h00,  4'h4, 4'h0, 0, 8'h00, 1, 1, 0, 8'h40, 8'hA5);
        add(0, 4'h4, 4'h0, 0, 0, 8'h00,  4'h4, 4'h0, 0, 8'h00, 1, 1, 0, 8'h40, 8'hA5);
        add(0, 4'h4, 4'h0, 0, 1, 8'h00,  4'h4, 4'h0, 0, 8'h00, 1, 1, 0, 8'h40, 8'hA5);
        add(0, 4'h4, 4'h0, 1, 0, 8'h3C,  4'h0, 4'h4, 0, 8'h3C, 0, 0, 0, 8'h40, 8'hA5);
        add(0, 4'h4, 4'h0, 1, 1, 8'h00,  4'h0, 4'h0, 0, 8'h3C, 0, 0, 0, 8'h40, 8'hA5);
        add(0, 4'h8, 4'h8, 1, 0, 8'h00,  4'h8, 4'h0, 0, 8'h3C, 1, 0, 1, 8'h33, 8'hD8);
        add(0, 4'h8, 4'h8, 1, 0, 8'h00,  4'h8, 4'h0, 0, 8'h3C, 1, 1, 1, 8'h33, 8'hD8);
        add(0, 4'h8, 4'h8, 1, 1, 8'h00,  4'h0, 4'h8, 1, 8'h3C, 0, 0, 1, 8'h33, 8'hD8);
        add(0, 4'hF, 4'h0, 1, 0, 8'h55,  4'h1, 4'h0, 0, 8'h3C, 1, 0, 0, 8'h12, 8'hD8);
        add(0, 4'hF, 4'h0, 1, 0, 8'h55,  4'h1, 4'h0, 0, 8'h3C, 1, 1, 0, 8'h12, 8'hD8);
        add(0, 4'hF, 4'h0, 1, 0, 8'h55,  4'h0, 4'h1, 0, 8'h55, 0, 0, 0, 8'h12, 8'hD8);
        add(0, 4'hF, 4'h0, 1, 0, 8'h66,  4'h2, 4'h0, 0, 8'h55, 1, 0, 0, 8'h21, 8'hD8);
        add(0, 4'hF, 4'h0, 1, 0, 8'h66,  4'h2, 4'h0, 0, 8'h55, 1, 1, 0, 8'h21, 8'hD8);
        add(0, 4'hF, 4'h0, 1, 0, 8'h66,  4'h0, 4'h2, 0, 8'h66, 0, 0, 0, 8'h21, 8'hD8);
        add(0, 4'hF, 4'h0, 1, 0, 8'h77,  4'h4, 4'h0, 0, 8'h66, 1, 0, 0, 8'h40, 8'hD8);
        add(0, 4'hF, 4'h0, 1, 0, 8'h77,  4'h4, 4'h0, 0, 8'h66, 1, 1, 0, 8'h40, 8'hD8);
        add(0, 4'hF, 4'h0, 1, 0, 8'h77,  4'h0, 4'h4, 0, 8'h77, 0, 0, 0, 8'h40, 8'hD8);
        add(0, 4'hF, 4'h0, 1, 0, 8'h88,  4'h8, 4'h0, 0, 8'h77, 1, 0, 0, 8'h33, 8'hD8);
        add(0, 4'hF, 4'h0, 1, 0, 8'h88,  4'h8, 4'h0, 0, 8'h77, 1, 1, 0, 8'h33, 8'hD8);
        add(0, 4'hF, 4'h0, 1, 0, 8'h88,  4'h0, 4'h8, 0, 8'h88, 0, 0, 0, 8'h33, 8'hD8);
        add(0, 4'hF, 4'h0, 1, 0, 8'h99,  4'h1, 4'h0, 0, 8'h88, 1, 0, 0, 8'h12, 8'hD8);
        add(0, 4'hF, 4'h0, 1, 0, 8'h99,  4'h1, 4'h0, 0, 8'h88, 1, 1, 0, 8'h12, 8'hD8);
        add(0, 4'hF, 4'h0, 1, 0, 8'h99,  4'h0, 4'h1, 0, 8'h99, 0, 0, 0, 8'h12, 8'hD8);
        add(0, 4'hF, 4'h0, 1, 0, 8'h00,  4'h2, 4'h0, 0, 8'h99, 1, 0, 0, 8'h21, 8'hD8);
        add(0, 4'hF, 4'h0, 0, 0, 8'h00,  4'h2, 4'h0, 0, 8'h99, 1, 1, 0, 8'h21, 8'hD8);
        add(0, 4'hF, 4'h0, 0, 0, 8'h00,  4'h2, 4'h0, 0, 8'h99, 1, 1, 0, 8'h21, 8'hD8);
        add(1, 4'hF, 4'h0, 0, 0, 8'h00,  4'h0, 4'h0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        add(0, 4'hF, 4'h0, 1, 0, 8'h00,  4'h1, 4'h0, 0, 8'h00, 1, 0, 0, 8'h12, 8'h00);
        for (int i = 0; i < tv.size(); i++) begin
            P_reset = tv[i].rst; req_valid = tv[i].v; req_rw = tv[i].rw;
            P_ready = tv[i].rdy; P_slverr = tv[i].se; P_rdata = tv[i].prd;
            step();
            chk("grant", i, req_grant, tv[i].g);
            chk("done", i, req_done, tv[i].d);
            chk("err", i, req_err, tv[i].e);
            chk("rdata", i, req_rdata, tv[i].rd);
            chk("psel", i, P_sel, tv[i].s);
            chk("penable", i, P_enable, tv[i].en);
            chk("pwrite", i, P_write, tv[i].wr);
            chk("paddr", i, P_addr, tv[i].a);
            chk("pwdata", i, P_wdata, tv[i].wd);
        end
        do_reset();
        req_valid = 4'h4; req_rw = 4'h4; P_ready = 1'b1;
        step();
        chk("drop_grant", 100, req_grant, 4'h4);
        chk("drop_wdata", 100, P_wdata, 8'hC7);
        req_valid = '0;
        step();
        step();
        chk("drop_done", 101, req_done, 4'h4);
        chk("drop_err", 101, req_err, 1'b0);
        do_reset();
        req_valid = 4'h1; req_rw = 4'h0; P_ready = 1'b0; P_rdata = 8'hEE;
`ifdef APB_TIMEOUT_EN
        n = 0;
        do begin
            step();
            n++;
        end while (req_done == 4'h0 && n < 40);
        chk("tmo_cycles", 200, n, 18);
        chk("tmo_done", 200, req_done, 4'h1);
        chk("tmo_err", 200, req_err, 1'b1);
        chk("tmo_rdata", 200, req_rdata, 8'h00);
        chk("tmo_psel", 200, P_sel, 1'b0);
`else
        step();
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (!P_sel || !P_enable || req_done != 4'h0) bad++;
        end
        chk("stuck_bad_cycles", 200, bad, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
